// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared ALU op codes, forward selects, control bundle and multiply FSM states.
package pipeline_pkg;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {MS_IDLE, MS_MUL} mul_state_e;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
        logic branch;
    } ctrl_t;

    // Select 11 falls back to the register-file value.
    function automatic logic [31:0] fwd(logic [1:0] sel, logic [31:0] rf, logic [31:0] w, logic [31:0] m);
        return sel == FWD_W ? w : sel == FWD_M ? m : rf;
    endfunction
endpackage

// File: rtl/iter_mul.sv
// iter_mul: shift-add multiplier consuming one multiplier bit per cycle.
module iter_mul
    import pipeline_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        active_o,
    output logic [31:0] product_o
);
    localparam int CW = MUL_CYCLES > 1 ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    mul_state_e  state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] a_q, b_q, acc_q;

    assign active_o  = state_q == MS_MUL;
    assign done_o    = active_o && cnt_q == LAST;
    assign busy_o    = (state_q == MS_IDLE && start_i) || (active_o && cnt_q != LAST);
    // a_q/b_q are pre-shifted, so bit 0 of b_q is multiplier bit k and a_q is a << k.
    assign product_o = acc_q + (b_q[0] ? a_q : 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else if (state_q == MS_IDLE) begin
            if (start_i) begin
                state_q <= MS_MUL;
                cnt_q   <= '0;
                a_q     <= a_i;
                b_q     <= b_i;
                acc_q   <= '0;
            end
        end else begin
            acc_q   <= product_o;
            a_q     <= a_q << 1;
            b_q     <= b_q >> 1;
            cnt_q   <= cnt_q + CW'(1);
            state_q <= done_o ? MS_IDLE : MS_MUL;
        end
    end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: MIPS execute stage with forwarding, iterative multiply and the EX/MEM register.
module ex_mem_stage
    import pipeline_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rd1E,
    input  logic [31:0] rd2E,
    input  logic [4:0]  RtE,
    input  logic [4:0]  RdE,
    input  logic [31:0] signimmE,
    input  logic [31:0] pcplus4E,
    input  logic        regwriteE,
    input  logic        memtoregE,
    input  logic        memwriteE,
    input  logic        branchE,
    input  logic [2:0]  alucontrolE,
    input  logic        alusrcE,
    input  logic        regdstE,
    input  logic [1:0]  forwardAE,
    input  logic [1:0]  forwardBE,
    input  logic [31:0] resultW,
    output logic        busyE,
    output logic        regwriteM,
    output logic        memtoregM,
    output logic        memwriteM,
    output logic        branchM,
    output logic        zeroM,
    output logic [31:0] aluoutM,
    output logic [31:0] writedataM,
    output logic [31:0] pcbranchM,
    output logic [4:0]  writeregM
);
    ctrl_t       ctl_e, ctl_d, ctl_q, mctl_q;
    logic [31:0] src_a, src_b, wd_e, alu_e, pcb_e, product;
    logic [31:0] alu_d, alu_q, wd_d, wd_q, pcb_d, pcb_q, mwd_q, mpcb_q;
    logic [4:0]  wr_e, wr_d, wr_q, mwr_q;
    logic        zero_d, zero_q, mul_busy, mul_done, mul_active;

    assign ctl_e = '{regwrite: regwriteE, memtoreg: memtoregE, memwrite: memwriteE, branch: branchE};
    assign src_a = fwd(forwardAE, rd1E, resultW, alu_q);
    assign wd_e  = fwd(forwardBE, rd2E, resultW, alu_q);
    assign src_b = alusrcE ? signimmE : wd_e;
    assign pcb_e = pcplus4E + (signimmE << 2);
    assign wr_e  = regdstE ? RdE : RtE;
    assign alu_e = alucontrolE == ALU_ADD ? src_a + src_b :
                   alucontrolE == ALU_SUB ? src_a - src_b :
                   alucontrolE == ALU_AND ? src_a & src_b :
                   alucontrolE == ALU_OR  ? src_a | src_b :
                   alucontrolE == ALU_SLT ? {31'd0, $signed(src_a) < $signed(src_b)} : 32'd0;
    assign busyE = mul_busy;

    iter_mul #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (alucontrolE == ALU_MUL),
        .a_i       (src_a),
        .b_i       (src_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .active_o  (mul_active),
        .product_o (product)
    );

    // While busy the register takes a bubble; on the final multiply cycle it takes the latched instruction.
    always_comb begin
        ctl_d  = '0;
        alu_d  = '0;
        wd_d   = '0;
        pcb_d  = '0;
        wr_d   = '0;
        zero_d = 1'b0;
        if (mul_done) begin
            ctl_d  = mctl_q;
            alu_d  = product;
            wd_d   = mwd_q;
            pcb_d  = mpcb_q;
            wr_d   = mwr_q;
            zero_d = product == 32'd0;
        end else if (!mul_busy) begin
            ctl_d  = ctl_e;
            alu_d  = alu_e;
            wd_d   = wd_e;
            pcb_d  = pcb_e;
            wr_d   = wr_e;
            zero_d = alu_e == 32'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mctl_q <= '0;
            mwd_q  <= '0;
            mpcb_q <= '0;
            mwr_q  <= '0;
        end else if (!mul_active) begin
            mctl_q <= ctl_e;
            mwd_q  <= wd_e;
            mpcb_q <= pcb_e;
            mwr_q  <= wr_e;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_q  <= '0;
            alu_q  <= '0;
            wd_q   <= '0;
            pcb_q  <= '0;
            wr_q   <= '0;
            zero_q <= 1'b0;
        end else begin
            ctl_q  <= ctl_d;
            alu_q  <= alu_d;
            wd_q   <= wd_d;
            pcb_q  <= pcb_d;
            wr_q   <= wr_d;
            zero_q <= zero_d;
        end
    end

    assign regwriteM  = ctl_q.regwrite;
    assign memtoregM  = ctl_q.memtoreg;
    assign memwriteM  = ctl_q.memwrite;
    assign branchM    = ctl_q.branch;
    assign zeroM      = zero_q;
    assign aluoutM    = alu_q;
    assign writedataM = wd_q;
    assign pcbranchM  = pcb_q;
    assign writeregM  = wr_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: randomized and directed checks of ex_mem_stage against a transaction-level model.
module tb_ex_mem_stage;
    localparam int MUL_CYCLES = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rd1E, rd2E, signimmE, pcplus4E, resultW;
    logic [4:0]  RtE, RdE;
    logic        regwriteE, memtoregE, memwriteE, branchE, alusrcE, regdstE;
    logic [2:0]  alucontrolE;
    logic [1:0]  forwardAE, forwardBE;
    logic        busyE, regwriteM, memtoregM, memwriteM, branchM, zeroM;
    logic [31:0] aluoutM, writedataM, pcbranchM;
    logic [4:0]  writeregM;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic        branch;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pcb;
        logic [4:0]  wr;
    } m_t;

    m_t exp_m, mul_res, act;
    int mul_left;

    always #5 clk = ~clk;

    ex_mem_stage #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .reset(reset), .rd1E(rd1E), .rd2E(rd2E), .RtE(RtE), .RdE(RdE),
        .signimmE(signimmE), .pcplus4E(pcplus4E), .regwriteE(regwriteE), .memtoregE(memtoregE),
        .memwriteE(memwriteE), .branchE(branchE), .alucontrolE(alucontrolE), .alusrcE(alusrcE),
        .regdstE(regdstE), .forwardAE(forwardAE), .forwardBE(forwardBE), .resultW(resultW),
        .busyE(busyE), .regwriteM(regwriteM), .memtoregM(memtoregM), .memwriteM(memwriteM),
        .branchM(branchM), .zeroM(zeroM), .aluoutM(aluoutM), .writedataM(writedataM),
        .pcbranchM(pcbranchM), .writeregM(writeregM)
    );

    assign act = {regwriteM, memtoregM, memwriteM, branchM, zeroM, aluoutM, writedataM, pcbranchM, writeregM};

    function automatic logic [31:0] fwdm(logic [1:0] sel, logic [31:0] rf);
        return sel == 2'd1 ? resultW : sel == 2'd2 ? exp_m.alu : rf;
    endfunction

    // What one instruction produces in EX, computed directly from the operation's meaning.
    function automatic m_t ex_calc();
        m_t r;
        logic [31:0] a, b;
        a    = fwdm(forwardAE, rd1E);
        r.wd = fwdm(forwardBE, rd2E);
        b    = alusrcE ? signimmE : r.wd;
        case (alucontrolE)
            3'b010:  r.alu = a + b;
            3'b110:  r.alu = a - b;
            3'b000:  r.alu = a & b;
            3'b001:  r.alu = a | b;
            3'b111:  r.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011:  r.alu = a * b;
            default: r.alu = 32'd0;
        endcase
        r.zero     = r.alu == 32'd0;
        r.pcb      = pcplus4E + signimmE * 32'd4;
        r.wr       = regdstE ? RdE : RtE;
        r.regwrite = regwriteE;
        r.memtoreg = memtoregE;
        r.memwrite = memwriteE;
        r.branch   = branchE;
        return r;
    endfunction

    function automatic bit model_busy();
        return (mul_left == 0 && alucontrolE == 3'b011) || mul_left > 1;
    endfunction

    // mul_left counts edges still to go before the product is delivered.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_m    <= '0;
            mul_left <= 0;
        end else if (mul_left == 0 && alucontrolE == 3'b011) begin
            exp_m    <= '0;
            mul_res  <= ex_calc();
            mul_left <= MUL_CYCLES;
        end else if (mul_left > 1) begin
            exp_m    <= '0;
            mul_left <= mul_left - 1;
        end else if (mul_left == 1) begin
            exp_m    <= mul_res;
            mul_left <= 0;
        end else begin
            exp_m    <= ex_calc();
        end
    end

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL %s: got %h expected all zero", name, act);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (act !== exp_m) begin
                errors++;
                $display("FAIL mout @%0t: got %h expected %h", $time, act, exp_m);
            end
            check("busyE", {31'd0, busyE}, {31'd0, model_busy()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rd1E = 0; rd2E = 0; signimmE = 0; pcplus4E = 0; resultW = 0; RtE = 0; RdE = 0;
        regwriteE = 0; memtoregE = 0; memwriteE = 0; branchE = 0; alusrcE = 0; regdstE = 0;
        alucontrolE = 3'b000; forwardAE = 0; forwardBE = 0;
    endtask

    task automatic rand_instr();
        logic [2:0] op;
        rd1E        = $urandom;
        rd2E        = ($urandom_range(0, 3) == 0) ? rd1E : $urandom;
        signimmE    = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15));
        pcplus4E    = $urandom;
        RtE         = 5'($urandom_range(0, 31));
        RdE         = 5'($urandom_range(0, 31));
        regwriteE   = 1'($urandom_range(0, 1));
        memtoregE   = 1'($urandom_range(0, 1));
        memwriteE   = 1'($urandom_range(0, 1));
        branchE     = 1'($urandom_range(0, 1));
        alusrcE     = 1'($urandom_range(0, 1));
        regdstE     = 1'($urandom_range(0, 1));
        op          = 3'($urandom_range(0, 7));
        if (op == 3'b011 && $urandom_range(0, 3) != 0) op = 3'b010;
        alucontrolE = op;
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        int nb = 0;
        int bub = 0;
        clear_in();
        rd1E = a; rd2E = b; alucontrolE = 3'b011; regwriteE = 1; regdstE = 1; RdE = 5'd9;
        for (int i = 0; i < MUL_CYCLES; i++) begin
            @(negedge clk);
            if (busyE === 1'b1) nb++;
            tick();
            if (regwriteM === 1'b0) bub++;
        end
        check("mul_busy_cycles", nb, MUL_CYCLES);
        check("mul_bubbles", bub, MUL_CYCLES);
        @(negedge clk);
        check("mul_last_busy", {31'd0, busyE}, 32'd0);
        tick();
        check("mul_result", aluoutM, e);
        check("mul_regwrite", {31'd0, regwriteM}, 32'd1);
        check("mul_writereg", {27'd0, writeregM}, 32'd9);
        clear_in();
    endtask

    initial begin
        clear_in();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check_zero("reset_state");
        reset = 1'b0;

        tick();
        rd1E = 5; resultW = 10; forwardAE = 2'b01; rd2E = 3; alucontrolE = 3'b010; regdstE = 1; RdE = 5'd7;
        @(negedge clk);
        check("add_busy", {31'd0, busyE}, 32'd0);
        tick();
        check("add_fwd_aluout", aluoutM, 32'd13);
        check("add_writereg", {27'd0, writeregM}, 32'd7);
        check("model_add", exp_m.alu, 32'd13);

        clear_in();
        rd1E = 32'h1234; rd2E = 32'h1234; alucontrolE = 3'b110; branchE = 1; signimmE = 4; pcplus4E = 32'h100;
        tick();
        check("br_zero", {31'd0, zeroM}, 32'd1);
        check("br_branch", {31'd0, branchM}, 32'd1);
        check("br_target", pcbranchM, 32'h110);

        clear_in();
        rd1E = 32'hFFFFFFFF; rd2E = 1; alucontrolE = 3'b111;
        tick();
        check("slt_neg_lt_pos", aluoutM, 32'd1);
        rd1E = 1; rd2E = 32'hFFFFFFFF;
        tick();
        check("slt_pos_lt_neg", aluoutM, 32'd0);

        clear_in();
        rd1E = 32'h1111; rd2E = 32'h2222; alucontrolE = 3'b010; regwriteE = 1; memwriteE = 1; RtE = 5'd3;
        tick();
        check("pre_reset_add", aluoutM, 32'h3333);
        rand_instr();
        alucontrolE = 3'b001;
        #2 reset = 1'b1;
        #1;
        check_zero("async_reset_out");
        check("async_reset_busy", {31'd0, busyE}, 32'd0);
        clear_in();
        @(negedge clk);
        #1 reset = 1'b0;
        tick();

        run_mul(32'd7, 32'd6, 32'd42);
        run_mul(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);

        rd1E = 7; rd2E = 6; alucontrolE = 3'b011; regwriteE = 1;
        repeat (16) tick();
        #2 reset = 1'b1;
        #1;
        check_zero("reset_mid_mul_out");
        clear_in();
        @(negedge clk);
        #1 reset = 1'b0;
        tick();
        run_mul(32'd7, 32'd6, 32'd42);

        for (int i = 0; i < 3000; i++) begin
            bit hold;
            @(negedge clk);
            hold = model_busy();
            tick();
            if (!hold) rand_instr();
            forwardAE = 2'($urandom_range(0, 3));
            forwardBE = 2'($urandom_range(0, 3));
            resultW   = $urandom;
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
